// File: rtl/hash_pkg.sv
// Shared definitions for the hash lookup path: default widths and slot field
// accessors. A slot is {valid, key[KEY_WIDTH-1:0], value}, MSB first.
package hash_pkg;

  localparam int DEF_DATA_LINES   = 4;
  localparam int DEF_BUCKET_SIZE  = 1;
  localparam int DEF_BUCKET_WIDTH = 16;
  localparam int DEF_KEY_WIDTH    = 7;
  localparam int DEF_CNT_WIDTH    = 16;

  // Accessors operate on a slot zero-extended to this width.
  localparam int MAX_SLOT_W = 64;
  typedef logic [MAX_SLOT_W-1:0] slot_bus_t;

  function automatic logic slot_valid(input slot_bus_t slot, input int bucket_w);
    return slot[bucket_w-1];
  endfunction

  function automatic slot_bus_t slot_key(input slot_bus_t slot, input int bucket_w,
                                         input int key_w);
    slot_bus_t mask;
    mask = (slot_bus_t'(1) << key_w) - slot_bus_t'(1);
    return (slot >> (bucket_w - 1 - key_w)) & mask;
  endfunction

  function automatic slot_bus_t slot_value(input slot_bus_t slot, input int bucket_w,
                                           input int key_w);
    slot_bus_t mask;
    mask = (slot_bus_t'(1) << (bucket_w - 1 - key_w)) - slot_bus_t'(1);
    return slot & mask;
  endfunction

endpackage

// File: rtl/onehot_priority_sel.sv
// Lowest-index-wins priority select: match vector -> one-hot plus any/multi flags.
module onehot_priority_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_match,
  output logic [N-1:0] o_onehot,
  output logic         o_any,
  output logic         o_multi
);

  // x & -x isolates the least significant set bit.
  assign o_onehot = i_match & (~i_match + N'(1));
  assign o_any    = |i_match;
  assign o_multi  = |(i_match & ~o_onehot);

endmodule

// File: rtl/bucket_match_stage.sv
// Two-stage key compare ahead of the one-hot bucket mux: S1 registers raw
// matches, S2 registers the priority-resolved select; includes lookup stats.
module bucket_match_stage
  import hash_pkg::*;
#(
  parameter int DATA_LINES   = DEF_DATA_LINES,
  parameter int BUCKET_SIZE  = DEF_BUCKET_SIZE,
  parameter int BUCKET_WIDTH = DEF_BUCKET_WIDTH,
  parameter int KEY_WIDTH    = DEF_KEY_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [KEY_WIDTH-1:0]                         in_key,
  input  logic [BUCKET_SIZE-1:0][BUCKET_WIDTH-1:0]     in_buckets [DATA_LINES],
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [BUCKET_SIZE-1:0][BUCKET_WIDTH-1:0]     out_buckets [DATA_LINES],
  output logic [DATA_LINES-1:0][BUCKET_SIZE-1:0]       out_sel,
  output logic                                         out_hit,
  output logic                                         out_multi_hit,
  output logic [KEY_WIDTH-1:0]                         out_key,
  input  logic                                         stat_clear,
  output logic [CNT_WIDTH-1:0]                         stat_lookups,
  output logic [CNT_WIDTH-1:0]                         stat_hits
);

  localparam int N = DATA_LINES * BUCKET_SIZE;

  typedef logic [BUCKET_SIZE-1:0][BUCKET_WIDTH-1:0] bucket_t;

  logic                 w_en;
  logic                 w_fire;
  logic [N-1:0]         w_match;
  logic [N-1:0]         w_onehot;
  logic                 w_any;
  logic                 w_multi;

  logic                 r_s1_valid;
  logic [KEY_WIDTH-1:0] r_s1_key;
  bucket_t              r_s1_buckets [DATA_LINES];
  logic [N-1:0]         r_s1_match;

  logic                 r_out_valid;
  logic [N-1:0]         r_out_sel;
  logic                 r_out_hit;
  logic                 r_out_multi;
  logic [KEY_WIDTH-1:0] r_out_key;
  bucket_t              r_out_buckets [DATA_LINES];

  logic [CNT_WIDTH-1:0] r_lookups;
  logic [CNT_WIDTH-1:0] r_hits;

  // Whole pipeline advances together; a stalled output freezes both stages.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;
  assign w_fire   = r_out_valid && out_ready;

  // Match index is line*BUCKET_SIZE+slot, so lowest index = lowest line, then slot.
  for (genvar gi = 0; gi < DATA_LINES; gi++) begin : g_line
    for (genvar gj = 0; gj < BUCKET_SIZE; gj++) begin : g_slot
      assign w_match[gi*BUCKET_SIZE+gj] =
          slot_valid(slot_bus_t'(in_buckets[gi][gj]), BUCKET_WIDTH) &&
          (KEY_WIDTH'(slot_key(slot_bus_t'(in_buckets[gi][gj]), BUCKET_WIDTH, KEY_WIDTH))
           == in_key);
    end
  end

  onehot_priority_sel #(.N(N)) u_prio (
    .i_match  (r_s1_match),
    .o_onehot (w_onehot),
    .o_any    (w_any),
    .o_multi  (w_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_key    <= '0;
      r_s1_match  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_out_hit   <= 1'b0;
      r_out_multi <= 1'b0;
      r_out_key   <= '0;
      for (int i = 0; i < DATA_LINES; i++) begin
        r_s1_buckets[i]  <= '0;
        r_out_buckets[i] <= '0;
      end
    end else if (w_en) begin
      r_s1_valid    <= in_valid;
      r_s1_key      <= in_key;
      r_s1_buckets  <= in_buckets;
      r_s1_match    <= w_match;
      r_out_valid   <= r_s1_valid;
      r_out_sel     <= w_onehot;
      r_out_hit     <= w_any;
      r_out_multi   <= w_multi;
      r_out_key     <= r_s1_key;
      r_out_buckets <= r_s1_buckets;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lookups <= '0;
      r_hits    <= '0;
    end else if (stat_clear) begin
      r_lookups <= '0;
      r_hits    <= '0;
    end else if (w_fire) begin
      if (r_lookups != '1) r_lookups <= r_lookups + 1'b1;
      if (r_out_hit && (r_hits != '1)) r_hits <= r_hits + 1'b1;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_sel       = r_out_sel;
  assign out_hit       = r_out_hit;
  assign out_multi_hit = r_out_multi;
  assign out_key       = r_out_key;
  assign out_buckets   = r_out_buckets;
  assign stat_lookups  = r_lookups;
  assign stat_hits     = r_hits;

endmodule

// File: tb/tb_bucket_match_stage.sv
// Directed bench for bucket_match_stage: 4 lines x 2 slots, 16-bit slots, 4-bit counters.
module tb_bucket_match_stage;

  localparam int DL = 4;
  localparam int BS = 2;
  localparam int BW = 16;
  localparam int KW = 7;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [KW-1:0] in_key = '0;
  logic [BS-1:0][BW-1:0] in_buckets [DL];
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BS-1:0][BW-1:0] out_buckets [DL];
  logic [DL-1:0][BS-1:0] out_sel;
  logic          out_hit;
  logic          out_multi_hit;
  logic [KW-1:0] out_key;
  logic          stat_clear = 1'b0;
  logic [CW-1:0] stat_lookups;
  logic [CW-1:0] stat_hits;

  int checks = 0;
  int failures = 0;

  // Streaming scenario state
  logic [KW-1:0] keys4 [5] = '{7'h01, 7'h02, 7'h03, 7'h04, 7'h05};
  logic [7:0]    sel4  [5] = '{8'h01, 8'h04, 8'h10, 8'h80, 8'h00};
  int            sent, rcv, stall_left, stalls;
  logic          seen;
  logic [7:0]    hold_sel;
  logic [KW-1:0] hold_key;

  bucket_match_stage #(
    .DATA_LINES(DL), .BUCKET_SIZE(BS), .BUCKET_WIDTH(BW), .KEY_WIDTH(KW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_buckets(in_buckets),
    .out_valid(out_valid), .out_ready(out_ready), .out_buckets(out_buckets),
    .out_sel(out_sel), .out_hit(out_hit), .out_multi_hit(out_multi_hit), .out_key(out_key),
    .stat_clear(stat_clear), .stat_lookups(stat_lookups), .stat_hits(stat_hits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic clear_buckets();
    for (int i = 0; i < DL; i++) in_buckets[i] = '0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); stat_clear = 1'b1;
    @(negedge clk); stat_clear = 1'b0;
  endtask

  // One request with no backpressure; returns on the negedge after the output handshake.
  task automatic do_one(input string tag, input logic [KW-1:0] key, input logic [7:0] esel,
                        input logic ehit, input logic emulti);
    @(negedge clk); in_valid = 1'b1; in_key = key;
    @(negedge clk); in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sel"}, 32'(out_sel), 32'(esel));
    check({tag, "_hit"}, 32'(out_hit), 32'(ehit));
    check({tag, "_multi"}, 32'(out_multi_hit), 32'(emulti));
    check({tag, "_key"}, 32'(out_key), 32'(key));
    @(negedge clk);
  endtask

  initial begin
    clear_buckets();
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_inrdy", 32'(in_ready), 32'd1);
    check("rst_sel", 32'(out_sel), 32'd0);
    check("rst_hit", 32'(out_hit), 32'd0);
    check("rst_lookups", 32'(stat_lookups), 32'd0);
    check("rst_hits", 32'(stat_hits), 32'd0);
    rst_n = 1'b1;

    // Single hit on line 2 slot 1
    in_buckets[2][1] = 16'hAA55;
    do_one("hit", 7'h2A, 8'h20, 1'b1, 1'b0);
    check("hit_bucket", 32'(out_buckets[2][1]), 32'h0000AA55);
    check("hit_lookups", 32'(stat_lookups), 32'd1);
    check("hit_hits", 32'(stat_hits), 32'd1);

    // Matching key but slot valid bit clear
    clear_buckets();
    in_buckets[0][0] = 16'h2A55;
    do_one("inv", 7'h2A, 8'h00, 1'b0, 1'b0);
    check("inv_lookups", 32'(stat_lookups), 32'd2);
    check("inv_hits", 32'(stat_hits), 32'd1);

    // Two matches: line 1 slot 1 beats line 3 slot 0
    clear_buckets();
    in_buckets[3][0] = 16'h9101;
    in_buckets[1][1] = 16'h9102;
    do_one("multi", 7'h11, 8'h08, 1'b1, 1'b1);
    check("multi_hits", 32'(stat_hits), 32'd2);

    // Back-to-back stream with a 4-cycle downstream stall
    pulse_clear();
    check("bp_clr", 32'(stat_lookups), 32'd0);
    clear_buckets();
    in_buckets[0][0] = 16'h8101;
    in_buckets[1][0] = 16'h8202;
    in_buckets[2][0] = 16'h8303;
    in_buckets[3][1] = 16'h8404;
    sent = 0; rcv = 0; stall_left = 0; stalls = 0; seen = 1'b0;
    hold_sel = '0; hold_key = '0;
    for (int c = 0; c < 40 && rcv < 5; c++) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall_left = 4;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      in_valid = (sent < 5);
      if (sent < 5) in_key = keys4[sent];
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        check("bp_inrdy", 32'(in_ready), 32'd0);
        if (stalls > 1) begin
          check("bp_sel_hold", 32'(out_sel), 32'(hold_sel));
          check("bp_key_hold", 32'(out_key), 32'(hold_key));
        end
        hold_sel = out_sel;
        hold_key = out_key;
      end
      if (out_valid && out_ready) begin
        check("bp_sel", 32'(out_sel), 32'(sel4[rcv]));
        check("bp_key", 32'(out_key), 32'(keys4[rcv]));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_rcv", 32'(rcv), 32'd5);
    check("bp_stalls", 32'(stalls), 32'd4);
    @(negedge clk);
    check("bp_drain", 32'(out_valid), 32'd0);
    check("bp_lookups", 32'(stat_lookups), 32'd5);
    check("bp_hits", 32'(stat_hits), 32'd4);

    // 17 hits saturate a 4-bit counter, then clear beats a same-cycle increment
    pulse_clear();
    clear_buckets();
    in_buckets[2][1] = 16'hAA55;
    @(negedge clk); in_valid = 1'b1; in_key = 7'h2A;
    repeat (17) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("sat_hits", 32'(stat_hits), 32'd15);
    check("sat_lookups", 32'(stat_lookups), 32'd15);
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    check("clr_valid", 32'(out_valid), 32'd1);
    stat_clear = 1'b1;
    @(negedge clk); stat_clear = 1'b0;
    check("clr_lookups", 32'(stat_lookups), 32'd0);
    check("clr_hits", 32'(stat_hits), 32'd0);

    // Asynchronous reset with requests in flight
    @(negedge clk); in_valid = 1'b1; in_key = 7'h2A;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("ar_pre_lookups", 32'(stat_lookups), 32'd1);
    check("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_lookups", 32'(stat_lookups), 32'd0);
    check("ar_hits", 32'(stat_hits), 32'd0);
    check("ar_sel", 32'(out_sel), 32'd0);
    check("ar_inrdy", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_noreplay", 32'(out_valid), 32'd0);
    do_one("ar_new", 7'h2A, 8'h20, 1'b1, 1'b0);
    check("ar_new_lookups", 32'(stat_lookups), 32'd1);
    check("ar_new_hits", 32'(stat_hits), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bucket_match_stage.md
Name: bucket_match_stage

Overview:
- Pipelined compare stage that sits directly upstream of the one-hot bucket multiplexer.
- Takes a search key plus the bucket read out of each of DATA_LINES hash tables, and compares the key against every valid slot.
- Produces the one-hot DATA_LINES x BUCKET_SIZE select vector, a hit flag, and the bucket data, aligned for the downstream mux.
- Has a valid/ready handshake on both sides, and keeps saturating lookup/hit statistics counters.

Parameters:
- DATA_LINES, 4: number of hash tables (ways) searched in parallel.
- BUCKET_SIZE, 1: slots per bucket.
- BUCKET_WIDTH, 16: bits per slot. Bit [BUCKET_WIDTH-1] is the valid flag, the next KEY_WIDTH bits are the key, and the remainder is the value.
- KEY_WIDTH, 7: key width. Must satisfy KEY_WIDTH <= BUCKET_WIDTH-1.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept a request.
- in_key  in  KEY_WIDTH  search key.
- in_buckets  in  [DATA_LINES] x [BUCKET_SIZE][BUCKET_WIDTH]  bucket read from each table (unpacked over lines, packed over slots).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_buckets  out  same shape as in_buckets  bucket data, delayed to align with out_sel.
- out_sel  out  [DATA_LINES][BUCKET_SIZE]  one-hot select; all zero on a miss.
- out_hit  out  1  at least one slot matched.
- out_multi_hit  out  1  more than one slot matched (table corruption indicator).
- out_key  out  KEY_WIDTH  key, delayed.
- stat_clear  in  1  synchronous clear of both counters.
- stat_lookups  out  CNT_WIDTH  number of completed lookups.
- stat_hits  out  CNT_WIDTH  number of completed lookups that hit.

Behaviour:
- Reset (rst_n low, asynchronous): both stage-valid flags, out_valid, out_sel, out_hit, out_multi_hit, out_buckets, out_key, stat_lookups and stat_hits all go to 0. in_ready is combinational, so it reads 1 while out_valid is 0.
- Reset mid-operation: in-flight requests are discarded, not replayed.
- Pipeline structure: two register stages.
  - S1 registers key, buckets, and the raw match vector. match[i][j] = slot valid bit AND (slot key == in_key).
  - S2 registers the priority-resolved out_sel, out_hit and out_multi_hit, plus the data from S1.
- Latency: 2 cycles from input handshake to out_valid when there is no backpressure. Throughput: 1 request per cycle.
- Flow control:
  - Global advance enable en = !out_valid || out_ready.
  - in_ready = en, a combinational path from out_ready.
  - When en=1, S1 loads the input (s1_valid <= in_valid) and S2 loads S1 (out_valid <= s1_valid).
  - When en=0, all stage registers hold.
  - Outputs stay stable while out_valid && !out_ready.
- Priority: the lowest line index wins, then the lowest slot index within that line. out_sel has exactly one bit set on a hit and is all zero on a miss.
- out_multi_hit = popcount(match) > 1. The priority winner is still selected.
- Slots with valid bit 0 never match, whatever their key bits.
- Counters:
  - On an output handshake (out_valid && out_ready), stat_lookups += 1, and stat_hits += 1 if out_hit.
  - Both counters saturate at all-ones.
  - stat_clear wins over a same-cycle increment; the counters read 0 on the next cycle.
- Bubbles: S1/S2 data registers may hold stale contents when their valid flag is 0. Downstream must qualify all outputs with out_valid.

Decomposition:
- Shared package hash_pkg holds:
  - slot field offset constants/functions: slot_valid(), slot_key(), slot_value(), taking BUCKET_WIDTH and KEY_WIDTH;
  - the default widths.
- One natural sub-module: onehot_priority_sel. It is combinational and parameterised on N = DATA_LINES*BUCKET_SIZE, mapping the match vector to a one-hot vector plus any/multi flags. It is reused elsewhere in the hash path.

Test Plan:
Configuration for all scenarios: DATA_LINES=4, BUCKET_SIZE=2, BUCKET_WIDTH=16, KEY_WIDTH=7.
1. Single hit, no backpressure: key 0x2A; line 2 slot 1 = 0xAA55 (valid, key 0x2A, value 0x55); all other slots 0x0000 -> out_valid on cycle +2, out_sel = line2 bit1 only, out_hit=1, out_multi_hit=0, stat_lookups=1, stat_hits=1.
2. Invalid-slot miss: key 0x2A; line 0 slot 0 = 0x2A55 (valid bit 0, key 0x2A) -> out_sel all zero, out_hit=0, stat_hits unchanged.
3. Multi-hit priority: key 0x11 valid in line 3 slot 0 and line 1 slot 1 -> out_sel = line1 bit1, out_hit=1, out_multi_hit=1.
4. Backpressure: stream 5 back-to-back requests, hold out_ready=0 for 4 cycles starting at the first out_valid -> in_ready=0 during the stall, outputs stable, no loss or duplication, results in order, stat_lookups=5.
5. Saturation and clear: CNT_WIDTH=4, 17 hits -> stat_hits=15. Then stat_clear coincident with a handshake -> both counters 0 on the next cycle.
6. Async reset mid-stream: drop rst_n between clock edges with two requests in flight -> out_valid=0 and counters 0 immediately. After release, in_ready=1 and a new request completes normally.
